// File: rtl/hvsync_frame_scheduler.sv
// Frame scheduler for hvsync_generator_enabled plus shared object-table port arbiter.
// Optional HBLANK_ACCESS_EN: game logic may also use the port in horizontal blanking.
module hvsync_frame_scheduler #(
    parameter int H_DISPLAY  = 640,
    parameter int H_MAX      = 799,
    parameter int V_DISPLAY  = 480,
    parameter int V_MAX      = 524,
    parameter int GAME_GUARD = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output logic       gen_en,
    output logic       gen_reset,
    output logic       frame_start,
    input  logic       disp_req,
    output logic       disp_grant,
    input  logic       game_req,
    input  logic       game_done,
    output logic       game_grant,
    output logic       overrun,
    output logic [7:0] overrun_cnt,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SCAN   = 2'b01,
        UPDATE = 2'b10,
        DRAIN  = 2'b11
    } state_t;

    localparam logic [9:0] LP_HD     = 10'(H_DISPLAY);
    localparam logic [9:0] LP_HMAX   = 10'(H_MAX);
    localparam logic [9:0] LP_VD     = 10'(V_DISPLAY);
    localparam logic [9:0] LP_VDLAST = 10'(V_DISPLAY - 1);
    localparam logic [9:0] LP_VCLOSE = 10'(V_MAX - GAME_GUARD);
    localparam logic [9:0] LP_VMAX   = 10'(V_MAX);

    state_t     r_state;
    state_t     w_next;
    logic       r_gen_en;
    logic       r_gen_reset;
    logic       r_frame_start;
    logic       r_overrun;
    logic [7:0] r_overrun_cnt;
    logic       w_line_end;
    logic       w_start;
    logic       w_overrun;
    logic       w_disp_grant;
    logic       w_hblank_grant;

    assign w_line_end = (hpos == LP_HMAX);

    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_overrun = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (run) begin
                    w_next  = SCAN;
                    w_start = 1'b1;
                end
            end
            SCAN: begin
                if (w_line_end && vpos == LP_VDLAST)
                    w_next = UPDATE;
            end
            UPDATE: begin
                // A done on the close cycle still counts as on time
                if (game_done) begin
                    w_next = DRAIN;
                end else if (w_line_end && vpos == LP_VCLOSE) begin
                    w_next    = DRAIN;
                    w_overrun = 1'b1;
                end
            end
            DRAIN: begin
                if (w_line_end && vpos == LP_VMAX) begin
                    if (run) begin
                        w_next  = SCAN;
                        w_start = 1'b1;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_gen_en      <= 1'b0;
            r_gen_reset   <= 1'b1;
            r_frame_start <= 1'b0;
            r_overrun     <= 1'b0;
            r_overrun_cnt <= 8'd0;
        end else begin
            r_state       <= w_next;
            r_gen_en      <= (w_next != IDLE);
            r_gen_reset   <= (w_next == IDLE);
            r_frame_start <= w_start;
            r_overrun     <= w_overrun;
            if (w_overrun && r_overrun_cnt != 8'hFF)
                r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign w_disp_grant = (r_state == SCAN) & disp_req
                        & (hpos < LP_HD) & (vpos < LP_VD);

`ifdef HBLANK_ACCESS_EN
    assign w_hblank_grant = (r_state == SCAN) & game_req
                          & ~w_disp_grant & (hpos >= LP_HD);
`else
    assign w_hblank_grant = 1'b0;
`endif

    assign disp_grant  = w_disp_grant;
    assign game_grant  = ((r_state == UPDATE) & game_req) | w_hblank_grant;
    assign gen_en      = r_gen_en;
    assign gen_reset   = r_gen_reset;
    assign frame_start = r_frame_start;
    assign overrun     = r_overrun;
    assign overrun_cnt = r_overrun_cnt;
    assign state       = r_state;

endmodule

// File: tb/tb_hvsync_frame_scheduler.sv
// Bench for hvsync_frame_scheduler: small timing, generator model, frame-level reference.
// Directed table, hand sequences for start/overrun/stop, then random stimulus.
module tb_hvsync_frame_scheduler;

    localparam int HD = 8;
    localparam int HM = 11;
    localparam int VD = 6;
    localparam int VM = 10;
    localparam int GG = 2;
    localparam int HT = HM + 1;
    localparam int FT = HT * (VM + 1);
    localparam int T_UPD   = VD * HT;
    localparam int T_CLOSE = (VM - GG) * HT + HM;
    localparam int T_LAST  = FT - 1;
`ifdef HBLANK_ACCESS_EN
    localparam bit HB = 1'b1;
`else
    localparam bit HB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       run = 1'b0;
    logic [9:0] hpos = '0;
    logic [9:0] vpos = '0;
    logic       gen_en;
    logic       gen_reset;
    logic       frame_start;
    logic       disp_req = 1'b0;
    logic       disp_grant;
    logic       game_req = 1'b0;
    logic       game_done = 1'b0;
    logic       game_grant;
    logic       overrun;
    logic [7:0] overrun_cnt;
    logic [1:0] state;

    int n_pass = 0;
    int n_total = 0;

    hvsync_frame_scheduler #(
        .H_DISPLAY(HD), .H_MAX(HM), .V_DISPLAY(VD),
        .V_MAX(VM), .GAME_GUARD(GG)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .hpos(hpos), .vpos(vpos),
        .gen_en(gen_en), .gen_reset(gen_reset),
        .frame_start(frame_start),
        .disp_req(disp_req), .disp_grant(disp_grant),
        .game_req(game_req), .game_done(game_done),
        .game_grant(game_grant),
        .overrun(overrun), .overrun_cnt(overrun_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    // hvsync_generator_enabled stand-in
    always @(posedge clk) begin
        if (gen_reset) begin
            hpos <= '0;
            vpos <= '0;
        end else if (gen_en) begin
            if (hpos == 10'(HM)) begin
                hpos <= '0;
                vpos <= (vpos == 10'(VM)) ? 10'd0 : vpos + 10'd1;
            end else begin
                hpos <= hpos + 10'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    // Frame-level reference: cycle index within frame plus per-frame flags
    bit m_act, m_done, m_closed, m_fs, m_ovr;
    int m_t, m_cnt;

    function automatic logic [1:0] m_state();
        if (!m_act) return 2'd0;
        if (m_t < T_UPD) return 2'd1;
        if (!m_done && !m_closed) return 2'd2;
        return 2'd3;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act <= 0; m_t <= 0; m_done <= 0; m_closed <= 0;
            m_fs <= 0; m_ovr <= 0; m_cnt <= 0;
        end else begin
            m_fs <= 0;
            m_ovr <= 0;
            if (!m_act) begin
                if (run) begin
                    m_act <= 1; m_t <= 0; m_done <= 0;
                    m_closed <= 0; m_fs <= 1;
                end
            end else begin
                if (m_state() == 2'd2) begin
                    if (game_done) m_done <= 1;
                    else if (m_t == T_CLOSE) begin
                        m_closed <= 1;
                        m_ovr <= 1;
                        if (m_cnt < 255) m_cnt <= m_cnt + 1;
                    end
                end
                if (m_t == T_LAST) begin
                    m_t <= 0; m_done <= 0; m_closed <= 0;
                    m_fs <= run; m_act <= run;
                end else begin
                    m_t <= m_t + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [1:0] st;
        int h, v;
        bit edg, egg;
        #2;
        st = m_state();
        h = m_t % HT;
        v = m_t / HT;
        edg = (st == 2'd1) && disp_req && h < HD && v < VD;
        egg = (st == 2'd2) ? game_req
            : (HB && st == 2'd1 && game_req && !edg && h >= HD);
        chk("cycle",
            {state, gen_en, gen_reset, frame_start, overrun,
             overrun_cnt, disp_grant, game_grant},
            {st, m_act, !m_act, m_fs, m_ovr, 8'(m_cnt), edg, egg});
        if (m_act)
            chk("pos", {hpos, vpos}, {10'(h), 10'(v)});
    end

    typedef struct {
        int h; int v;
        bit dr; bit gr; bit gd;
        logic [1:0] st; bit dg; bit gg;
    } vec_t;
    vec_t tbl[10];

    task automatic wait_pos(input int h, input int v, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            disp_req = 0; game_req = 0; game_done = 0;
            n++;
        end while (!(hpos == 10'(h) && vpos == 10'(v)) && n < 400);
        if (!(hpos == 10'(h) && vpos == 10'(v))) timeout(nm);
    endtask

    task automatic do_reset(input bit run_after);
        @(negedge clk);
        reset_n = 0;
        repeat (3) @(negedge clk);
        run = run_after;
        reset_n = 1;
    endtask

    initial begin
        tbl[0] = '{0, 0, 1, 1, 0, 2'd1, 1, 0};
        tbl[1] = '{7, 5, 1, 0, 0, 2'd1, 1, 0};
        tbl[2] = '{8, 5, 1, 1, 0, 2'd1, 0, HB};
        tbl[3] = '{11, 5, 0, 1, 0, 2'd1, 0, HB};
        tbl[4] = '{0, 6, 1, 1, 0, 2'd2, 0, 1};
        tbl[5] = '{5, 7, 0, 0, 0, 2'd2, 0, 0};
        tbl[6] = '{3, 8, 1, 1, 1, 2'd2, 0, 1};
        tbl[7] = '{4, 8, 1, 1, 0, 2'd3, 0, 0};
        tbl[8] = '{11, 10, 1, 1, 0, 2'd3, 0, 0};
        tbl[9] = '{0, 0, 1, 0, 0, 2'd1, 1, 0};

        // Reset and start, then frame period
        do_reset(1'b1);
        @(negedge clk);
        #3;
        chk("start", {gen_en, gen_reset, frame_start, state},
            {1'b1, 1'b0, 1'b1, 2'd1});
        begin
            int k = 0;
            do begin @(negedge clk); k++; end
            while (!frame_start && k < 3 * FT);
            if (!frame_start) timeout("frame_period");
            else chk("frame_period", 64'(k), 64'(FT));
        end

        // Directed single frame
        foreach (tbl[i]) begin
            wait_pos(tbl[i].h, tbl[i].v, "table_pos");
            disp_req = tbl[i].dr;
            game_req = tbl[i].gr;
            game_done = tbl[i].gd;
            #3;
            chk("table", {state, disp_grant, game_grant},
                {tbl[i].st, tbl[i].dg, tbl[i].gg});
        end

        // Async reset in the middle of UPDATE
        begin
            int k = 0;
            do begin @(negedge clk); game_done = 0; k++; end
            while (state != 2'd2 && k < 3 * FT);
            if (state != 2'd2) timeout("reach_update");
            game_req = 1;
            disp_req = 1;
            #1;
            reset_n = 0;
            #1;
            chk("mid_reset", {state, gen_en, gen_reset, disp_grant,
                game_grant, frame_start, overrun, overrun_cnt},
                {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
        end
        game_req = 0;
        disp_req = 0;
        do_reset(1'b1);

        // Overrun pulse position and saturation
        begin
            int k = 0;
            do begin @(negedge clk); k++; end
            while (!overrun && k < 3 * FT);
            if (!overrun) timeout("overrun_wait");
            #3;
            chk("overrun", {state, hpos, vpos, overrun_cnt},
                {2'd3, 10'd0, 10'(VM - 1), 8'd1});
            @(negedge clk);
            #3;
            chk("overrun_pulse", {overrun, overrun_cnt}, {1'b0, 8'd1});
            repeat (300 * FT) @(negedge clk);
            #3;
            chk("overrun_sat", 64'(overrun_cnt), 64'd255);
        end

        // Stop mid-frame: the frame must finish before IDLE
        begin
            int k = 0;
            bit fs_seen = 0;
            wait_pos(3, 2, "stop_pos");
            run = 0;
            do begin @(negedge clk); k++; end
            while (state != 2'd0 && k < 3 * FT);
            #3;
            chk("stop_len", 64'(k), 64'(FT - (2 * HT + 3)));
            chk("stop_out", {gen_en, gen_reset, frame_start},
                {1'b0, 1'b1, 1'b0});
            repeat (FT + 5) begin
                @(negedge clk);
                fs_seen |= frame_start;
            end
            chk("stop_idle", {fs_seen, state}, {1'b0, 2'd0});
        end

        // Random traffic against the reference
        do_reset(1'b1);
        repeat (2500) begin
            @(negedge clk);
            run = ($urandom_range(0, 9) != 0);
            disp_req = $urandom_range(0, 1) == 1;
            game_req = $urandom_range(0, 1) == 1;
            game_done = ($urandom_range(0, 29) == 0);
        end

        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
